fractal_sync_2x2: RTL and testbench



---
 rtl/fractal_sync_pkg.sv | 70 +++++++
 rtl/fractal_sync_nbr.sv | 64 ++++++
 rtl/fractal_sync_node.sv | 131 +++++++++++++
 rtl/fractal_sync_2x2.sv | 113 +++++++++++
 tb/tb_fractal_sync_2x2.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: request/response bundles and topology helper
// for the 2x2 barrier-synchronization tile.
package fractal_sync_pkg;

  localparam int AGGR_W      = 3;
  localparam int LVL_W       = 1;
  localparam int ID_W        = 2;
  localparam int ROOT_AGGR_W = 1;
  localparam int NBR_AGGR_W  = 1;
  localparam int NBR_LVL_W   = 1;
  localparam int NBR_ID_W    = 1;

  typedef struct packed {
    logic [AGGR_W-1:0] aggr;
    logic [ID_W-1:0]   id;
  } req_sig_t;

  typedef struct packed {
    logic     sync;
    req_sig_t sig;
  } fsync_req_t;

  typedef struct packed {
    logic [LVL_W-1:0] lvl;
    logic [ID_W-1:0]  id;
  } rsp_sig_t;

  typedef struct packed {
    logic     wake;
    rsp_sig_t sig;
    logic     error;
  } fsync_rsp_t;

  typedef struct packed {
    logic [ROOT_AGGR_W-1:0] aggr;
    logic [ID_W-1:0]        id;
  } root_sig_t;

  typedef struct packed {
    logic      sync;
    root_sig_t sig;
  } root_req_t;

  typedef struct packed {
    logic [NBR_AGGR_W-1:0] aggr;
    logic [NBR_ID_W-1:0]   id;
  } nbr_req_sig_t;

  typedef struct packed {
    logic         sync;
    nbr_req_sig_t sig;
  } nbr_req_t;

  typedef struct packed {
    logic [NBR_LVL_W-1:0] lvl;
    logic [NBR_ID_W-1:0]  id;
  } nbr_rsp_sig_t;

  typedef struct packed {
    logic         wake;
    nbr_rsp_sig_t sig;
    logic         error;
  } nbr_rsp_t;

  // t=0 pairs a row (2k, 2k+1), t=1 pairs a column (k, k+2)
  function automatic int child_idx(int t, int k, int c);
    return (t == 0) ? (2 * k + c) : (k + 2 * c);
  endfunction

endpackage

// File: rtl/fractal_sync_nbr.sv
// fractal_sync_nbr: point-to-point barrier between two neighbour CUs.
module fractal_sync_nbr
  import fractal_sync_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  nbr_req_t req_i [2],
  output nbr_rsp_t rsp_o [2]
);

  logic [1:0]                p_q, p_d;
  logic [1:0][NBR_ID_W-1:0]  id_q, id_d;
  logic [1:0]                w_q, w_d;
  logic [1:0]                e_q, e_d;
  logic [1:0][NBR_ID_W-1:0]  oid_q, oid_d;
  logic [1:0]                ep;
  logic [1:0][NBR_ID_W-1:0]  eid;
  logic                      unused_aggr;

  assign unused_aggr = ^{req_i[0].sig.aggr, req_i[1].sig.aggr};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      ep[c]  = p_q[c] | req_i[c].sync;
      eid[c] = req_i[c].sync ? req_i[c].sig.id : id_q[c];
    end
    p_d   = ep;
    id_d  = eid;
    w_d   = '0;
    e_d   = '0;
    oid_d = '0;
    if (&ep) begin
      p_d   = 2'b00;
      oid_d = eid;
      if (eid[0] == eid[1]) w_d = 2'b11;
      else                  e_d = 2'b11;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q   <= '0;
      id_q  <= '0;
      w_q   <= '0;
      e_q   <= '0;
      oid_q <= '0;
    end else begin
      p_q   <= p_d;
      id_q  <= id_d;
      w_q   <= w_d;
      e_q   <= e_d;
      oid_q <= oid_d;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_rsp
    assign rsp_o[c] = '{
      wake:  w_q[c],
      sig:   '{lvl: '0, id: oid_q[c]},
      error: e_q[c]
    };
  end

endmodule

// File: rtl/fractal_sync_node.sv
// fractal_sync_node: two-child barrier aggregation node with
// per-id arrival masks, registered upward request and downward pulses.
module fractal_sync_node #(
  parameter int AW = 3,
  parameter int IW = 2,
  parameter int LW = 1,
  parameter logic [LW-1:0] LVL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        sync_i,
  input  logic [1:0][AW-1:0] aggr_i,
  input  logic [1:0][IW-1:0] id_i,
  output logic              sync_o,
  output logic [AW-2:0]     aggr_o,
  output logic [IW-1:0]     id_o,
  input  logic              up_wake_i,
  input  logic              up_error_i,
  input  logic [LW-1:0]     up_lvl_i,
  input  logic [IW-1:0]     up_id_i,
  output logic [1:0]        wake_o,
  output logic [1:0]        error_o,
  output logic [1:0][LW-1:0] lvl_o,
  output logic [1:0][IW-1:0] dn_id_o
);

  localparam int N = 1 << IW;

  logic [N-1:0][1:0]    mask_q, mask_d;
  logic [N-1:0][AW-1:0] aggr_q, aggr_d;
  logic                 sync_q, sync_d;
  logic [AW-2:0]        uaggr_q, uaggr_d;
  logic [IW-1:0]        uid_q, uid_d;
  logic [1:0]           wake_q, wake_d;
  logic [1:0]           err_q, err_d;
  logic [1:0][LW-1:0]   lvl_q, lvl_d;
  logic [1:0][IW-1:0]   did_q, did_d;

  logic [1:0]    arr, nw;
  logic [AW-1:0] a0, a1;

  always_comb begin
    mask_d  = mask_q;
    aggr_d  = aggr_q;
    sync_d  = 1'b0;
    uaggr_d = '0;
    uid_d   = '0;
    wake_d  = '0;
    err_d   = '0;
    lvl_d   = '0;
    did_d   = '0;
    arr     = '0;
    nw      = '0;
    a0      = '0;
    a1      = '0;
    for (int j = 0; j < N; j++) begin
      for (int c = 0; c < 2; c++) begin
        arr[c] = sync_i[c] && (id_i[c] == IW'(j));
        if (arr[c] && mask_q[j][c]) begin
          err_d[c] = 1'b1;
          lvl_d[c] = LVL;
          did_d[c] = IW'(j);
        end
      end
      nw = arr & ~mask_q[j];
      a0 = nw[0] ? aggr_i[0] : aggr_q[j];
      a1 = nw[1] ? aggr_i[1] : aggr_q[j];
      if (nw != 2'b00) begin
        if ((mask_q[j] | nw) == 2'b11) begin
          mask_d[j] = 2'b00;
          if (a0 != a1) begin
            err_d = 2'b11;
            lvl_d = {LVL, LVL};
            did_d = {IW'(j), IW'(j)};
          end else if (a0[0]) begin
            sync_d  = 1'b1;
            uaggr_d = a0[AW-1:1];
            uid_d   = IW'(j);
          end else begin
            wake_d = 2'b11;
            lvl_d  = {LVL, LVL};
            did_d  = {IW'(j), IW'(j)};
          end
        end else begin
          mask_d[j] = mask_q[j] | nw;
          aggr_d[j] = nw[0] ? aggr_i[0] : aggr_i[1];
        end
      end
    end
    // a wake or error from above fans out to both children
    if (up_wake_i || up_error_i) begin
      wake_d = wake_d | {2{up_wake_i}};
      err_d  = err_d | {2{up_error_i}};
      lvl_d  = {up_lvl_i, up_lvl_i};
      did_d  = {up_id_i, up_id_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q  <= '0;
      aggr_q  <= '0;
      sync_q  <= 1'b0;
      uaggr_q <= '0;
      uid_q   <= '0;
      wake_q  <= '0;
      err_q   <= '0;
      lvl_q   <= '0;
      did_q   <= '0;
    end else begin
      mask_q  <= mask_d;
      aggr_q  <= aggr_d;
      sync_q  <= sync_d;
      uaggr_q <= uaggr_d;
      uid_q   <= uid_d;
      wake_q  <= wake_d;
      err_q   <= err_d;
      lvl_q   <= lvl_d;
      did_q   <= did_d;
    end
  end

  assign sync_o  = sync_q;
  assign aggr_o  = uaggr_q;
  assign id_o    = uid_q;
  assign wake_o  = wake_q;
  assign error_o = err_q;
  assign lvl_o   = lvl_q;
  assign dn_id_o = did_q;

endmodule

// File: rtl/fractal_sync_2x2.sv
// fractal_sync_2x2: h/v barrier trees (two levels each) plus
// neighbour links for a 2x2 tile of compute units.
module fractal_sync_2x2
  import fractal_sync_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  fsync_req_t h_1d_fsync_req_i [4][1],
  output fsync_rsp_t h_1d_fsync_rsp_o [4][1],
  input  fsync_req_t v_1d_fsync_req_i [4][1],
  output fsync_rsp_t v_1d_fsync_rsp_o [4][1],
  input  nbr_req_t   h_nbr_fsycn_req_i [4],
  output nbr_rsp_t   h_nbr_fsycn_rsp_o [4],
  input  nbr_req_t   v_nbr_fsycn_req_i [4],
  output nbr_rsp_t   v_nbr_fsycn_rsp_o [4],
  output root_req_t  h_2d_fsync_req_o [1][1],
  input  fsync_rsp_t h_2d_fsync_rsp_i [1][1],
  output root_req_t  v_2d_fsync_req_o [1][1],
  input  fsync_rsp_t v_2d_fsync_rsp_i [1][1]
);

  fsync_req_t treq [2][4];
  fsync_rsp_t trsp [2][4];
  nbr_req_t   nreq [2][4];
  nbr_rsp_t   nrsp [2][4];
  fsync_rsp_t up   [2];
  root_req_t  rq   [2];

  for (genvar i = 0; i < 4; i++) begin : g_io
    assign treq[0][i] = h_1d_fsync_req_i[i][0];
    assign treq[1][i] = v_1d_fsync_req_i[i][0];
    assign h_1d_fsync_rsp_o[i][0] = trsp[0][i];
    assign v_1d_fsync_rsp_o[i][0] = trsp[1][i];
    assign nreq[0][i] = h_nbr_fsycn_req_i[i];
    assign nreq[1][i] = v_nbr_fsycn_req_i[i];
    assign h_nbr_fsycn_rsp_o[i] = nrsp[0][i];
    assign v_nbr_fsycn_rsp_o[i] = nrsp[1][i];
  end

  assign up[0] = h_2d_fsync_rsp_i[0][0];
  assign up[1] = v_2d_fsync_rsp_i[0][0];
  assign h_2d_fsync_req_o[0][0] = rq[0];
  assign v_2d_fsync_req_o[0][0] = rq[1];

  for (genvar t = 0; t < 2; t++) begin : g_t
    logic [1:0]                  l1s;
    logic [1:0][AGGR_W-2:0]      l1a;
    logic [1:0][ID_W-1:0]        l1i;
    logic [1:0]                  l2w, l2e;
    logic [1:0][LVL_W-1:0]       l2l;
    logic [1:0][ID_W-1:0]        l2i;
    logic                        rs;
    logic [ROOT_AGGR_W-1:0]      ra;
    logic [ID_W-1:0]             ri;

    for (genvar k = 0; k < 2; k++) begin : g_k
      logic [1:0]             cs, w, e;
      logic [1:0][AGGR_W-1:0] ca;
      logic [1:0][ID_W-1:0]   ci, di;
      logic [1:0][LVL_W-1:0]  dl;
      nbr_req_t               nq [2];
      nbr_rsp_t               ns [2];

      for (genvar c = 0; c < 2; c++) begin : g_c
        localparam int CI = child_idx(t, k, c);
        assign cs[c] = treq[t][CI].sync;
        assign ca[c] = treq[t][CI].sig.aggr;
        assign ci[c] = treq[t][CI].sig.id;
        assign trsp[t][CI] = '{
          wake:  w[c],
          sig:   '{lvl: dl[c], id: di[c]},
          error: e[c]
        };
        assign nq[c] = nreq[t][CI];
        assign nrsp[t][CI] = ns[c];
      end

      fractal_sync_node #(
        .AW(AGGR_W), .IW(ID_W), .LW(LVL_W),
        .LVL(LVL_W'(0))
      ) u_l1 (
        .clk_i, .rst_i,
        .sync_i(cs), .aggr_i(ca), .id_i(ci),
        .sync_o(l1s[k]), .aggr_o(l1a[k]), .id_o(l1i[k]),
        .up_wake_i(l2w[k]), .up_error_i(l2e[k]),
        .up_lvl_i(l2l[k]), .up_id_i(l2i[k]),
        .wake_o(w), .error_o(e),
        .lvl_o(dl), .dn_id_o(di)
      );

      fractal_sync_nbr u_nbr (
        .clk_i, .rst_i,
        .req_i(nq), .rsp_o(ns)
      );
    end

    fractal_sync_node #(
      .AW(AGGR_W-1), .IW(ID_W), .LW(LVL_W),
      .LVL(LVL_W'(1))
    ) u_l2 (
      .clk_i, .rst_i,
      .sync_i(l1s), .aggr_i(l1a), .id_i(l1i),
      .sync_o(rs), .aggr_o(ra), .id_o(ri),
      .up_wake_i(up[t].wake), .up_error_i(up[t].error),
      .up_lvl_i(up[t].sig.lvl), .up_id_i(up[t].sig.id),
      .wake_o(l2w), .error_o(l2e),
      .lvl_o(l2l), .dn_id_o(l2i)
    );

    assign rq[t] = '{sync: rs, sig: '{aggr: ra, id: ri}};
  end

endmodule

// File: tb/tb_fractal_sync_2x2.sv
// tb_fractal_sync_2x2: directed scoreboard bench for the 2x2 tile.
module tb_fractal_sync_2x2;
  import fractal_sync_pkg::*;

  logic clk = 1'b0;
  logic rst;
  fsync_req_t h_req [4][1];
  fsync_rsp_t h_rsp [4][1];
  fsync_req_t v_req [4][1];
  fsync_rsp_t v_rsp [4][1];
  nbr_req_t   hn_req [4];
  nbr_rsp_t   hn_rsp [4];
  nbr_req_t   vn_req [4];
  nbr_rsp_t   vn_rsp [4];
  root_req_t  h2_req [1][1];
  fsync_rsp_t h2_rsp [1][1];
  root_req_t  v2_req [1][1];
  fsync_rsp_t v2_rsp [1][1];

  fractal_sync_2x2 dut (
    .clk_i(clk), .rst_i(rst),
    .h_1d_fsync_req_i(h_req), .h_1d_fsync_rsp_o(h_rsp),
    .v_1d_fsync_req_i(v_req), .v_1d_fsync_rsp_o(v_rsp),
    .h_nbr_fsycn_req_i(hn_req), .h_nbr_fsycn_rsp_o(hn_rsp),
    .v_nbr_fsycn_req_i(vn_req), .v_nbr_fsycn_rsp_o(vn_rsp),
    .h_2d_fsync_req_o(h2_req), .h_2d_fsync_rsp_i(h2_rsp),
    .v_2d_fsync_req_o(v2_req), .v_2d_fsync_rsp_i(v2_rsp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         port;
    int         idx;
    logic [7:0] val;
    logic [7:0] msk;
  } exp_t;

  exp_t sb [$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ports: 0 h-tree, 1 v-tree, 2 h-nbr, 3 v-nbr, 4 h root, 5 v root
  function automatic logic [7:0] pk(logic w, logic e, int l, int id);
    return {w, e, 3'(l), 3'(id)};
  endfunction

  function automatic logic [7:0] obs(int p, int i);
    case (p)
      0: return pk(h_rsp[i][0].wake, h_rsp[i][0].error,
                   int'(h_rsp[i][0].sig.lvl), int'(h_rsp[i][0].sig.id));
      1: return pk(v_rsp[i][0].wake, v_rsp[i][0].error,
                   int'(v_rsp[i][0].sig.lvl), int'(v_rsp[i][0].sig.id));
      2: return pk(hn_rsp[i].wake, hn_rsp[i].error,
                   int'(hn_rsp[i].sig.lvl), int'(hn_rsp[i].sig.id));
      3: return pk(vn_rsp[i].wake, vn_rsp[i].error,
                   int'(vn_rsp[i].sig.lvl), int'(vn_rsp[i].sig.id));
      4: return pk(h2_req[0][0].sync, 1'b0,
                   int'(h2_req[0][0].sig.aggr), int'(h2_req[0][0].sig.id));
      default: return pk(v2_req[0][0].sync, 1'b0,
                   int'(v2_req[0][0].sig.aggr), int'(v2_req[0][0].sig.id));
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] o, logic [7:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      h_req[i][0] = '0;
      v_req[i][0] = '0;
      hn_req[i]   = '0;
      vn_req[i]   = '0;
    end
    h2_rsp[0][0] = '0;
    v2_rsp[0][0] = '0;
  endtask

  task automatic push_exp(int lat, int p, int i,
                          logic [7:0] v, logic [7:0] m);
    exp_t x;
    x.due = cyc + lat; x.port = p; x.idx = i;
    x.val = v; x.msk = m;
    sb.push_back(x);
  endtask

  task automatic treq(int t, int i, logic [2:0] a, int id);
    fsync_req_t r;
    r.sync = 1'b1;
    r.sig.aggr = a;
    r.sig.id = ID_W'(id);
    if (t == 0) h_req[i][0] = r;
    else        v_req[i][0] = r;
  endtask

  task automatic nreq(int t, int i, int id);
    nbr_req_t r;
    r.sync = 1'b1;
    r.sig.aggr = '0;
    r.sig.id = NBR_ID_W'(id);
    if (t == 0) hn_req[i] = r;
    else        vn_req[i] = r;
  endtask

  task automatic tick();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    clear_inputs();
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < ((p < 4) ? 4 : 1); i++) begin
        k = -1;
        foreach (sb[j])
          if (k < 0 && sb[j].due == cyc && sb[j].port == p &&
              sb[j].idx == i) k = j;
        if (k >= 0) begin
          check($sformatf("evt_p%0d_i%0d_c%0d", p, i, cyc),
                obs(p, i) & sb[k].msk, sb[k].val & sb[k].msk);
          sb.delete(k);
        end else begin
          check($sformatf("idle_p%0d_i%0d_c%0d", p, i, cyc),
                obs(p, i) & 8'hC0, 8'h00);
        end
      end
    end
  endtask

  logic [2:0] ag;

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < ((p < 4) ? 4 : 1); i++)
        check($sformatf("reset_p%0d_i%0d", p, i), obs(p, i), 8'h00);
    rst = 1'b0;
    tick();

    // level-2 barrier on the h-tree
    for (int i = 0; i < 4; i++) begin
      treq(0, i, 3'b001, 0);
      push_exp(3, 0, i, pk(1, 0, 1, 0), 8'hFF);
    end
    repeat (4) tick();

    // level-1 pair barrier, CU1 five cycles late
    treq(0, 0, 3'b000, 2);
    repeat (5) tick();
    treq(0, 1, 3'b000, 2);
    push_exp(1, 0, 0, pk(1, 0, 0, 2), 8'hFF);
    push_exp(1, 0, 1, pk(1, 0, 0, 2), 8'hFF);
    repeat (2) tick();

    // two concurrent column barriers, distinct ids
    treq(1, 0, 3'b000, 1);
    treq(1, 2, 3'b000, 1);
    treq(1, 1, 3'b000, 3);
    treq(1, 3, 3'b000, 3);
    push_exp(1, 1, 0, pk(1, 0, 0, 1), 8'hFF);
    push_exp(1, 1, 2, pk(1, 0, 0, 1), 8'hFF);
    push_exp(1, 1, 1, pk(1, 0, 0, 3), 8'hFF);
    push_exp(1, 1, 3, pk(1, 0, 0, 3), 8'hFF);
    repeat (2) tick();

    // duplicate request: error to CU0 only, barrier survives
    treq(0, 0, 3'b000, 0);
    tick();
    treq(0, 0, 3'b000, 0);
    push_exp(1, 0, 0, pk(0, 1, 0, 0), 8'hC0);
    repeat (3) tick();
    treq(0, 1, 3'b000, 0);
    push_exp(1, 0, 0, pk(1, 0, 0, 0), 8'hFF);
    push_exp(1, 0, 1, pk(1, 0, 0, 0), 8'hFF);
    repeat (2) tick();

    // mismatched aggregate: error to both, entry cleared
    treq(0, 2, 3'b000, 1);
    treq(0, 3, 3'b001, 1);
    push_exp(1, 0, 2, pk(0, 1, 0, 0), 8'hC0);
    push_exp(1, 0, 3, pk(0, 1, 0, 0), 8'hC0);
    repeat (2) tick();
    treq(0, 2, 3'b000, 1);
    treq(0, 3, 3'b000, 1);
    push_exp(1, 0, 2, pk(1, 0, 0, 1), 8'hFF);
    push_exp(1, 0, 3, pk(1, 0, 0, 1), 8'hFF);
    repeat (2) tick();

    // forwarded out of the root, then woken from above
    ag = 3'b011;
    for (int i = 0; i < 4; i++) treq(0, i, ag, 1);
    push_exp(2, 4, 0, pk(1, 0, int'(ag >> 2), 1), 8'hFF);
    repeat (3) tick();
    h2_rsp[0][0] = '{wake: 1'b1, sig: '{lvl: 1'b1, id: 2'd1},
                     error: 1'b0};
    for (int i = 0; i < 4; i++)
      push_exp(2, 0, i, pk(1, 0, 1, 1), 8'hFF);
    repeat (3) tick();

    // neighbour links
    nreq(0, 0, 1);
    nreq(0, 1, 1);
    push_exp(1, 2, 0, pk(1, 0, 0, 1), 8'hFF);
    push_exp(1, 2, 1, pk(1, 0, 0, 1), 8'hFF);
    tick();
    nreq(0, 2, 0);
    nreq(0, 3, 1);
    push_exp(1, 2, 2, pk(0, 1, 0, 0), 8'hC0);
    push_exp(1, 2, 3, pk(0, 1, 0, 0), 8'hC0);
    tick();
    nreq(1, 1, 0);
    tick();
    nreq(1, 3, 0);
    push_exp(1, 3, 1, pk(1, 0, 0, 0), 8'hFF);
    push_exp(1, 3, 3, pk(1, 0, 0, 0), 8'hFF);
    repeat (2) tick();

    // reset mid-barrier drops pending requests
    nreq(0, 0, 1);
    treq(0, 0, 3'b000, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nreq(0, 1, 1);
    treq(0, 1, 3'b000, 3);
    repeat (3) tick();

    check("scoreboard_empty", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
